// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO controller that drives the dual-port mem block.
package fifo_pkg;

    localparam int unsigned FIFO_DWIDTH = 32;
    localparam int unsigned FIFO_AWIDTH = 8;

    typedef logic [FIFO_AWIDTH-1:0] addr_t;
    typedef logic [FIFO_AWIDTH:0]   cnt_t;

    // Fill level never exceeds 2**AWIDTH, so the MSB alone marks full.
    function automatic logic is_full(cnt_t cnt);
        return cnt[FIFO_AWIDTH];
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// AWIDTH-bit wrapping address counter with synchronous reset.
module fifo_ptr #(
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              inc_i,
    output logic [AWIDTH-1:0] ptr_o
);

    logic [AWIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Single-clock FIFO controller: push/pop interface, fill tracking and flags, driving an
// external dual-port mem with one cycle of read latency.
module fifo_mem_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH       = FIFO_DWIDTH,
    parameter int unsigned AWIDTH       = FIFO_AWIDTH,
    parameter int unsigned ALMOST_FULL  = 240,
    parameter int unsigned ALMOST_EMPTY = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              rd_valid_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              ovf_o,
    output logic              udf_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [AWIDTH-1:0] mem_wr_addr_o,
    output logic              mem_wr_ena_o,
    output logic [AWIDTH-1:0] mem_rd_addr_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam cnt_t AfLevel = cnt_t'(ALMOST_FULL);
    localparam cnt_t AeLevel = cnt_t'(ALMOST_EMPTY);

    logic              wr_acc, rd_acc;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;

    cnt_t usedw_q, usedw_d;
    logic empty_q, empty_d;
    logic full_q, full_d;
    logic af_q, af_d;
    logic ae_q, ae_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic rd_valid_q, rd_valid_d;

    fifo_ptr #(
        .AWIDTH (AWIDTH)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .inc_i  (wr_acc),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr #(
        .AWIDTH (AWIDTH)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .inc_i  (rd_acc),
        .ptr_o  (rd_ptr)
    );

    // Acceptance looks only at registered flags, so a same-cycle pop never frees room for a
    // push while full, nor does a same-cycle push feed a pop while empty.
    always_comb begin
        wr_acc     = wrreq_i & ~full_q;
        rd_acc     = rdreq_i & ~empty_q;
        usedw_d    = usedw_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
        empty_d    = (usedw_d == '0);
        full_d     = is_full(usedw_d);
        af_d       = (usedw_d >= AfLevel);
        ae_d       = (usedw_d < AeLevel);
        ovf_d      = ovf_q | (wrreq_i & full_q);
        udf_d      = udf_q | (rdreq_i & empty_q);
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            usedw_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= (ALMOST_EMPTY > 0);
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            usedw_q    <= usedw_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign mem_wr_ena_o   = wr_acc;
    assign mem_wr_addr_o  = wr_ptr;
    assign mem_data_o     = data_i;
    assign mem_rd_addr_o  = rd_ptr;

    assign q_o            = mem_data_i;
    assign rd_valid_o     = rd_valid_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign usedw_o        = usedw_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Randomized bench for fifo_mem_ctrl with a behavioural mem and a queue-based reference model.
module tb_fifo_mem_ctrl;

    localparam int Depth = 256;
    localparam int Af    = 240;
    localparam int Ae    = 16;

    logic        clk = 1'b0;
    logic        srst;
    logic [31:0] data;
    logic        wrreq, rdreq;
    logic [31:0] q;
    logic        rd_valid, empty, full, almost_full, almost_empty, ovf, udf;
    logic [8:0]  usedw;
    logic [31:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_waddr, mem_raddr;
    logic        mem_wena;

    logic [31:0] mem_array [Depth];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];    // reference FIFO contents
    logic [31:0] exp_q[$];  // data expected on q_o, in order
    logic        m_ovf, m_udf, m_rv;

    always #5 clk = ~clk;

    fifo_mem_ctrl #(
        .DWIDTH       (32),
        .AWIDTH       (8),
        .ALMOST_FULL  (Af),
        .ALMOST_EMPTY (Ae)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .data_i         (data),
        .wrreq_i        (wrreq),
        .rdreq_i        (rdreq),
        .q_o            (q),
        .rd_valid_o     (rd_valid),
        .empty_o        (empty),
        .full_o         (full),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .usedw_o        (usedw),
        .ovf_o          (ovf),
        .udf_o          (udf),
        .mem_data_o     (mem_wdata),
        .mem_wr_addr_o  (mem_waddr),
        .mem_wr_ena_o   (mem_wena),
        .mem_rd_addr_o  (mem_raddr),
        .mem_data_i     (mem_rdata)
    );

    // Dual-port mem: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_wena) mem_array[mem_waddr] <= mem_wdata;
        mem_rdata <= mem_array[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_status();
        int n;
        n = m_q.size();
        chk("usedw", 32'(usedw), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == Depth));
        chk("almost_full", 32'(almost_full), 32'(n >= Af));
        chk("almost_empty", 32'(almost_empty), 32'(n < Ae));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    endtask

    // One clock with the given request; the model decides acceptance from its own fill level.
    task automatic cycle(input logic wr, input logic rd, input logic [31:0] d);
        logic wa, ra;
        wrreq = wr;
        rdreq = rd;
        data  = d;
        wa = wr && (m_q.size() < Depth);
        ra = rd && (m_q.size() > 0);
        @(posedge clk);
        if (wr && !wa) m_ovf = 1'b1;
        if (rd && !ra) m_udf = 1'b1;
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(d);
        m_rv = ra;
        #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        check_status();
    endtask

    task automatic do_reset(input int n, input logic rd);
        srst  = 1'b1;
        rdreq = rd;
        wrreq = 1'b0;
        repeat (n) @(posedge clk);
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rv  = 1'b0;
        #1;
        srst  = 1'b0;
        rdreq = 1'b0;
        check_status();
    endtask

    // Monitor: every valid output word must be the next scoreboard entry.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q_unexpected at %0t: got %0h, expected no valid word", $time, q);
            end else begin
                chk("q", q, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        srst  = 1'b1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rv  = 1'b0;

        // Reset
        do_reset(2, 1'b0);

        // Fill to full, then one dropped push
        for (int i = 0; i < Depth; i++) cycle(1'b1, 1'b0, 32'(i));
        cycle(1'b1, 1'b0, 32'hdead_beef);
        chk("full_after_fill", 32'(full), 32'd1);
        chk("ovf_after_fill", 32'(ovf), 32'd1);

        // Drain, then one dropped pop
        for (int i = 0; i < Depth; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        chk("udf_after_drain", 32'(udf), 32'd1);

        // Random traffic across pointer wrap
        pushed = 0;
        while (pushed < 600) begin
            logic w, r;
            w = (m_q.size() < 200) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) == 0);
            if (w) pushed++;
            cycle(w, r, $urandom);
        end
        while (m_q.size() > 0) cycle(1'b0, ($urandom_range(0, 1) == 1), '0);
        cycle(1'b0, 1'b0, '0);

        // Simultaneous push+pop at level 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, $urandom);
        chk("usedw_simul", 32'(usedw), 32'd5);

        // Simultaneous push+pop while full: pop wins, push dropped
        while (m_q.size() < Depth) cycle(1'b1, 1'b0, $urandom);
        cycle(1'b1, 1'b1, $urandom);
        chk("usedw_full_simul", 32'(usedw), 32'd255);
        while (m_q.size() > 0) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // Reset mid-stream at level 10 with a pop in flight
        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, $urandom);
        cycle(1'b0, 1'b1, '0);
        do_reset(1, 1'b1);
        chk("usedw_after_mid_reset", 32'(usedw), 32'd0);
        cycle(1'b0, 1'b0, '0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
